uart_tx_par: RTL and testbench
==============================

Name: uart_tx_par

Overview:
- Serial UART transmitter with an optional parity bit; the transmit-side counterpart of the parity-checking receiver.
- Sits between the TX FIFO and the tx pin, paced by the shared baud-rate tick generator (16 ticks per bit).
- Frame: start bit, DBIT data bits LSB first, optional parity bit, stop bits.
- Parity uses the same convention the receiver checks, so loopback produces a parity match.

Parameters:
- DBIT, 8, number of data bits (1..8).
- SB_TICK, 16, s_tick count for the stop period (16/24/32 = 1/1.5/2 stop bits).
- PARITY_EN, 1, 1 = insert a parity bit after the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_start  input  1  request to send din; acted on only in IDLE.
- s_tick  input  1  one-clk pulse, 16 per bit period.
- din  input  8  data to send; bits [DBIT-1:0] are used.
- tx_done_tick  output  1  one-clk pulse at end of the stop period.
- tx_busy  output  1  high whenever state is not IDLE.
- tx  output  1  serial line, registered, idle-high.

Behaviour:
- Reset (async) values:
  - state = IDLE; tick counter s = 0; bit counter n = 0; shift register b = 0; parity register p = 0.
  - tx = 1, tx_done_tick = 0, tx_busy = 0.
  - Reset mid-frame aborts the frame immediately: tx returns to 1 asynchronously and no done pulse is produced.
- State machine:
  - IDLE, START, DATA, PARITY, STOP.
  - tx is a register loaded from tx_next. It therefore reflects the current state one clk after each state change.
- IDLE:
  - tx_next = 1.
  - If tx_start = 1: b <= din, p <= (^din[DBIT-1:0]) XOR PARITY_ODD, s <= 0, go to START.
  - If tx_start = 0: remain in IDLE.
- START:
  - tx_next = 0.
  - On s_tick: if s = 15, then s <= 0, n <= 0, go to DATA; otherwise s <= s+1.
- DATA:
  - tx_next = b[0].
  - On s_tick with s = 15: s <= 0, b <= b >> 1.
    - If n = DBIT-1, go to PARITY when PARITY_EN = 1, otherwise to STOP.
    - Otherwise n <= n+1.
  - On s_tick with s < 15: s <= s+1.
- PARITY:
  - tx_next = p.
  - On s_tick: if s = 15, then s <= 0, go to STOP; otherwise s <= s+1.
- STOP:
  - tx_next = 1.
  - On s_tick with s = SB_TICK-1: tx_done_tick = 1 (combinational, this cycle only), go to IDLE.
  - Otherwise, on s_tick: s <= s+1.
- Latency:
  - tx_start sampled high at edge k → state = START after edge k → tx = 0 after edge k+1.
  - Frame length = 16*(1+DBIT+PARITY_EN) + SB_TICK s_ticks.
- Handshake rules:
  - tx_start is ignored whenever state ≠ IDLE, including the tx_done_tick cycle.
  - The earliest accept is the cycle after tx_done_tick. With tx_start held high this gives back-to-back frames with no idle bit period.
  - din is sampled only at acceptance. Changes to din mid-frame have no effect.
- Tick handling:
  - With s_tick = 0, all counters and the state hold.
  - s_tick arriving in the same cycle as acceptance is not counted.
- Widths:
  - s is 5 bits, enough for SB_TICK-1 up to 31.
  - n is 3 bits and wraps only through explicit reset to 0.
- tx_busy = (state ≠ IDLE), combinational from the state register.

Test Plan:
- DBIT=8, PARITY_EN=1, PARITY_ODD=0, s_tick every 4 clk, din=0x55 → tx bits (each 64 clk): 0,1,0,1,0,1,0,1,0, parity 0, stop 1 (64 clk). tx_done_tick is one clk wide, and tx_busy deasserts the next clk.
- Same config, din=0x07 → parity bit 1. With PARITY_ODD=1 and din=0x55 → parity bit 1. Loop tx back into the receiver: parity match asserted, received byte matches din.
- PARITY_EN=0, din=0xA3 → exactly 10 bit periods: 0, 1,1,0,0,0,1,0,1, 1. No parity slot.
- tx_start held high with din changing 0x11 → 0x22 mid-frame: first frame carries 0x11. Second frame starts after tx_done_tick with no extra idle period and carries the din value at re-acceptance. tx_start pulses during the first frame are ignored.
- SB_TICK=32: stop period lasts 32 s_ticks (128 clk at tick/4), and tx_done_tick fires on the 32nd stop tick.
- Reset asserted during DATA bit 3 → tx = 1 and tx_busy = 0 immediately, no tx_done_tick. After release, a new tx_start with din=0xFF produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_par.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity bit, stop period.
// Paced by a 16x oversampling s_tick; tx is registered and idles high.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | driving start bit (16 ticks)
// DATA   | shifting out b[0], DBIT bits of 16 ticks each
// PARITY | driving parity bit p (16 ticks)
// STOP   | line high for SB_TICK ticks, done pulse on last tick
module uart_tx_par #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic       s_tick,
   input  logic [7:0] din,
   output logic       tx_done_tick,
   output logic       tx_busy,
   output logic       tx
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t      state, state_next;
   logic [4:0]  s, s_next;
   logic [2:0]  n, n_next;
   logic [7:0]  b, b_next;
   logic        p, p_next;
   logic        tx_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         s     <= '0;
         n     <= '0;
         b     <= '0;
         p     <= 1'b0;
         tx    <= 1'b1;
      end else begin
         state <= state_next;
         s     <= s_next;
         n     <= n_next;
         b     <= b_next;
         p     <= p_next;
         tx    <= tx_next;
      end
   end

   always_comb begin
      state_next = state;
      s_next     = s;
      n_next     = n;
      b_next     = b;
      p_next     = p;
      unique case (state)
         IDLE: begin
            if (tx_start) begin
               b_next     = din;
               p_next     = (^din[DBIT-1:0]) ^ 1'(PARITY_ODD);
               s_next     = '0;
               state_next = START;
            end
         end
         START: begin
            if (s_tick) begin
               if (s == 5'd15) begin
                  s_next     = '0;
                  n_next     = '0;
                  state_next = DATA;
               end else begin
                  s_next = s + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s == 5'd15) begin
                  s_next = '0;
                  b_next = b >> 1;
                  if (n == 3'(DBIT - 1))
                     state_next = (PARITY_EN != 0) ? PARITY : STOP;
                  else
                     n_next = n + 3'd1;
               end else begin
                  s_next = s + 5'd1;
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s == 5'd15) begin
                  s_next     = '0;
                  state_next = STOP;
               end else begin
                  s_next = s + 5'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s == 5'(SB_TICK - 1))
                  state_next = IDLE;
               else
                  s_next = s + 5'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_next      = 1'b1;
      tx_done_tick = 1'b0;
      tx_busy      = (state != IDLE);
      unique case (state)
         IDLE:    tx_next = 1'b1;
         START:   tx_next = 1'b0;
         DATA:    tx_next = b[0];
         PARITY:  tx_next = p;
         STOP: begin
            tx_next      = 1'b1;
            tx_done_tick = s_tick && (s == 5'(SB_TICK - 1));
         end
         default: tx_next = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_par.sv
// Bench for uart_tx_par: four parameter variants share stimulus, each compared per clock
// against a tick-count frame model; instance 0 is also decoded by a loopback receiver.
module tb_uart_tx_par;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic       s_tick;
   logic [7:0] din;
   logic       tx_o[4];
   logic       busy_o[4];
   logic       done_o[4];

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_par #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
      .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
      .tx_done_tick(done_o[0]), .tx_busy(busy_o[0]), .tx(tx_o[0]));
   uart_tx_par #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
      .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
      .tx_done_tick(done_o[1]), .tx_busy(busy_o[1]), .tx(tx_o[1]));
   uart_tx_par #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_nopar (
      .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
      .tx_done_tick(done_o[2]), .tx_busy(busy_o[2]), .tx(tx_o[2]));
   uart_tx_par #(.DBIT(8), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(0)) dut_sb32 (
      .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
      .tx_done_tick(done_o[3]), .tx_busy(busy_o[3]), .tx(tx_o[3]));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pe_of(input int i);
      return (i == 2) ? 0 : 1;
   endfunction
   function automatic int po_of(input int i);
      return (i == 1) ? 1 : 0;
   endfunction
   function automatic int sb_of(input int i);
      return (i == 3) ? 32 : 16;
   endfunction
   function automatic int total_of(input int i);
      return 16 * (1 + 8 + pe_of(i)) + sb_of(i);
   endfunction

   // Reference: one tick counter per frame; line level = frame bit (ticks/16), then stop
   logic       m_busy[4];
   int         m_cnt[4];
   logic [10:0] m_bits[4];
   logic       m_tx[4];
   logic [7:0] rx_q[$];
   logic       rx_abort;

   function automatic logic level_of(input int i);
      int idx;
      idx = m_cnt[i] / 16;
      if (!m_busy[i]) return 1'b1;
      if (idx < 1 + 8 + pe_of(i)) return m_bits[i][idx];
      return 1'b1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
            m_tx[i]   = 1'b1;
         end
         rx_q.delete();
         rx_abort = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            logic nxt;
            nxt = level_of(i);
            if (!m_busy[i]) begin
               if (tx_start) begin
                  m_bits[i] = '1;
                  m_bits[i][0] = 1'b0;
                  for (int k = 0; k < 8; k++) m_bits[i][1+k] = din[k];
                  if (pe_of(i) != 0)
                     m_bits[i][9] = 1'(($countones(din) + po_of(i)) % 2);
                  m_busy[i] = 1'b1;
                  m_cnt[i]  = 0;
                  if (i == 0) rx_q.push_back(din);
               end
            end else if (s_tick) begin
               m_cnt[i]++;
               if (m_cnt[i] == total_of(i)) m_busy[i] = 1'b0;
            end
            m_tx[i] = nxt;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("tx%0d", i), 32'(tx_o[i]), 32'(m_tx[i]));
         chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_busy[i]));
         chk($sformatf("done%0d", i), 32'(done_o[i]),
             32'(m_busy[i] && s_tick && (m_cnt[i] + 1 == total_of(i))));
      end
   end

   // s_tick every 4 clk
   initial begin
      int tc = 0;
      s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         tc++;
         s_tick = (tc % 4 == 0);
      end
   end

   // Loopback receiver on the even-parity instance (64 clk per bit, mid-bit sampling)
   initial begin
      logic [7:0] rbyte;
      logic       rstart, rpar, rstop;
      forever begin
         @(negedge tx_o[0]);
         rx_abort = 1'b0;
         repeat (32) @(posedge clk);
         #1 rstart = tx_o[0];
         for (int k = 0; k < 8; k++) begin
            repeat (64) @(posedge clk);
            #1 rbyte[k] = tx_o[0];
         end
         repeat (64) @(posedge clk);
         #1 rpar = tx_o[0];
         repeat (64) @(posedge clk);
         #1 rstop = tx_o[0];
         if (!rx_abort) begin
            chk("rx_start", 32'(rstart), 32'd0);
            chk("rx_parity_match", 32'(^{rbyte, rpar}), 32'd0);
            chk("rx_stop", 32'(rstop), 32'd1);
            if (rx_q.size() > 0) chk("rx_byte", 32'(rbyte), 32'(rx_q.pop_front()));
            else chk("rx_unexpected_frame", 32'd1, 32'd0);
         end
      end
   end

   task automatic wait_idle(input int max_clk);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < max_clk && !ok; c++) begin
         @(negedge clk);
         ok = !(busy_o[0] || busy_o[1] || busy_o[2] || busy_o[3]);
      end
      chk("idle_timeout", 32'(ok), 32'd1);
   endtask

   task automatic send(input logic [7:0] d);
      @(posedge clk);
      #2;
      tx_start = 1'b1;
      din      = d;
      @(posedge clk);
      #2;
      tx_start = 1'b0;
      wait_idle(2000);
   endtask

   initial begin
      logic hit;
      for (int i = 0; i < 4; i++) begin
         m_busy[i] = 1'b0;
         m_cnt[i]  = 0;
         m_tx[i]   = 1'b1;
      end
      rx_abort = 1'b1;
      reset    = 1'b1;
      tx_start = 1'b0;
      din      = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_tx", 32'(tx_o[0]), 32'd1);
      chk("rst_busy", 32'(busy_o[0]), 32'd0);
      chk("rst_done", 32'(done_o[0]), 32'd0);
      reset = 1'b0;
      repeat (4) @(posedge clk);

      send(8'h55);
      send(8'h07);
      send(8'hA3);
      send(8'h00);

      // held tx_start, din changes mid-frame
      @(posedge clk);
      #2;
      tx_start = 1'b1;
      din      = 8'h11;
      repeat (100) @(posedge clk);
      #2 din = 8'h22;
      repeat (1400) @(posedge clk);
      #2 tx_start = 1'b0;
      wait_idle(2000);

      // random traffic with tx_start pulses landing mid-frame
      for (int it = 0; it < 40; it++) begin
         @(posedge clk);
         #2;
         din      = 8'($urandom);
         tx_start = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(1, 200)) @(posedge clk);
      end
      #2 tx_start = 1'b0;
      wait_idle(2000);

      // reset during data bit 3 of instance 0
      @(posedge clk);
      #2;
      tx_start = 1'b1;
      din      = 8'hC6;
      @(posedge clk);
      #2 tx_start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         @(negedge clk);
         hit = m_busy[0] && (m_cnt[0] >= 72) && (m_cnt[0] < 80);
      end
      chk("reach_data_bit3", 32'(hit), 32'd1);
      #1 reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("abort_tx%0d", i), 32'(tx_o[i]), 32'd1);
         chk($sformatf("abort_busy%0d", i), 32'(busy_o[i]), 32'd0);
         chk($sformatf("abort_done%0d", i), 32'(done_o[i]), 32'd0);
      end
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      repeat (800) @(posedge clk);
      send(8'hFF);
      repeat (100) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
